// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the 4-way arbitrated data mux: requester count,
// FSM state encoding and small index helpers.
package mux_ctrl_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot vector for a requester index.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4x1.sv
// Single-bit 4:1 multiplexer; the arbiter's data path uses one per data bit.
module mux4x1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    // Plain indexed select; d[i] appears on y when sel == i.
    always_comb begin
        y = d[sel];
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter in front of a 4:1 data mux. A granted requester keeps
// the mux until it drops its request or has moved MAX_HOLD words downstream.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; picks the next requester after last_winner when req != 0
//   GRANT | requester sel owns the mux; words move on out_valid & out_ready
//
module mux4_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   data_in,
    output logic [N_REQ-1:0]      grant,
    output logic [SEL_W-1:0]      sel,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int              HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t             state;
    logic [HW-1:0]      hold_cnt;
    logic [SEL_W-1:0]   last_winner;
    logic [SEL_W-1:0]   pick;
    logic               xfer;
    logic               release_now;

    // First requester with req high, searching upward from last+1 modulo 4.
    // Returns last when nobody requests; the caller only uses it when req != 0.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Handshake and release decode for the current grant.
    always_comb begin
        pick        = rr_pick(req, last_winner);
        out_valid   = (state == GRANT) & req[sel];
        xfer        = out_valid & out_ready;
        release_now = !req[sel] || (xfer && (hold_cnt == HOLD_LAST));
    end

    // Arbiter FSM; grant and sel are registered so the select never glitches
    // on request changes. Release always passes through one IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            sel         <= '0;
            hold_cnt    <= '0;
            last_winner <= SEL_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        sel   <= pick;
                        grant <= idx_to_onehot(pick);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= '0;
                        hold_cnt    <= '0;
                        last_winner <= sel;
                    end else if (xfer) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Data path: one 4:1 bit mux per data bit, all steered by sel.
    for (genvar b = 0; b < DW; b++) begin : g_bit
        mux4x1 u_mux (
            .d   ({data_in[3*DW+b], data_in[2*DW+b], data_in[DW+b], data_in[b]}),
            .sel (sel),
            .y   (out_data[b])
        );
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter. Stimulus pushes each expected downstream
// transfer {grant, sel, data} into a queue; a monitor pops and compares on
// every out_valid & out_ready cycle. Cycle-level grant/sel checks are inline.
module tb_mux4_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [13:0] sb[$];
    logic [7:0]  words[4];

    mux4_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int r);
        logic [3:0] g;
        g = 4'b0001 << r;
        sb.push_back({g, 2'(r), words[r]});
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    initial begin
        logic [13:0] exp;
        forever begin
            @(negedge clk);
            check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL xfer_unexpected: got grant=%b sel=%0d data=%h, required no transfer",
                             grant, sel, out_data);
                end else begin
                    exp = sb.pop_front();
                    check("xfer", 32'({grant, sel, out_data}), 32'(exp));
                end
            end
        end
    end

    initial begin
        logic [3:0] eg;
        words   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        data_in = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

        // Reset state, then a single request from requester 2.
        do_reset();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        req = 4'b0100;
        tick();
        @(negedge clk);
        check("r2_grant", 32'(grant), 32'h4);
        check("r2_sel", 32'(sel), 32'h2);
        check("r2_valid", 32'(out_valid), 32'h1);
        check("r2_data", 32'(out_data), 32'hCC);
        req = 4'b0000;
        tick();
        tick();

        // All requesting, downstream always ready: 0,1,2,3,0,1,2,3 with gaps.
        do_reset();
        for (int g = 0; g < 8; g++)
            for (int t = 0; t < 4; t++)
                push(g % 4);
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            @(negedge clk);
            eg = ((c - 1) % 5 == 4) ? 4'b0000 : (4'b0001 << (((c - 1) / 5) % 4));
            check("rr_grant", 32'(grant), 32'(eg));
        end
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();

        // Requester 1 stalled by downstream for 10 cycles while others request.
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1111;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("stall_grant", 32'(grant), 32'h2);
            check("stall_sel", 32'(sel), 32'h1);
            check("stall_data", 32'(out_data), 32'hBB);
            check("stall_valid", 32'(out_valid), 32'h1);
            tick();
        end
        for (int t = 0; t < 4; t++) push(1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        @(negedge clk);
        check("stall_release", 32'(grant), 32'h0);
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();

        // Requester 2 drops after 2 transfers; next picks honour last_winner.
        do_reset();
        push(2);
        push(2);
        req       = 4'b0100;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("drop_valid", 32'(out_valid), 32'h0);
        check("drop_hold", 32'(grant), 32'h4);
        tick();
        req       = 4'b0101;
        out_ready = 1'b0;
        @(negedge clk);
        check("drop_release", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check("after2_grant", 32'(grant), 32'h1);
        check("after2_sel", 32'(sel), 32'h0);
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0101;
        @(negedge clk);
        check("rel0_grant", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check("after0_grant", 32'(grant), 32'h4);
        check("after0_sel", 32'(sel), 32'h2);
        req = 4'b0000;
        tick();
        tick();

        // Reset while requester 3 holds the grant.
        do_reset();
        req = 4'b1000;
        tick();
        @(negedge clk);
        check("r3_grant", 32'(grant), 32'h8);
        check("r3_sel", 32'(sel), 32'h3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_sel", 32'(sel), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        tick();
        @(negedge clk);
        check("postrst_grant", 32'(grant), 32'h1);
        check("postrst_sel", 32'(sel), 32'h0);
        req = 4'b0000;
        tick();
        tick();

        // Mux sweep: each requester in turn drives out_data.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001 << i;
            tick();
            @(negedge clk);
            check("sweep_sel", 32'(sel), 32'(i));
            check("sweep_data", 32'(out_data), 32'(words[i]));
            req = 4'b0000;
            tick();
        end

        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
